adder_issue_stage: RTL and testbench

Operand issue stage in front of the parallel-prefix adder. It accepts add/subtract requests over a valid/ready handshake and buffers them in a 2-entry FIFO. The FIFO head drives the combinational adder's `A`/`B`/`c0` inputs, and the stage registers the adder's `WIDTH+1`-bit result, with carry and signed overflow, into a valid/ready output slot. Sustained throughput is one operation per cycle, with no combinational path from `out_ready` to `in_ready`.

---
 rtl/adder_issue_stage_if.sv | 31 +++
 rtl/adder_issue_stage.sv | 134 +++++++++++++
 tb/tb_adder_issue_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_issue_stage_if.sv
// Request/response handshake bundle for the adder issue stage.
// The stage itself connects through the slave modport.
interface adder_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic [TAGW-1:0]  in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );
endinterface

// File: rtl/adder_issue_stage.sv
// Operand issue stage: 2-entry request FIFO feeding an external combinational
// prefix adder, with the adder result registered into a valid/ready output slot.
module adder_issue_stage #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4,
    parameter int TAGW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_issue_stage_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_c0,
    input  logic [WIDTH:0]   add_s
);

    generate
        if (GROUPSIZE < 1 || (WIDTH % GROUPSIZE) != 0) begin : g_bad_groupsize
            $error("adder_issue_stage: WIDTH must be a multiple of GROUPSIZE");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [TAGW-1:0]  tag;
    } req_t;

    req_t             fifo_q [2];
    req_t             fifo_d [2];
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
    logic [TAGW-1:0]  out_tag_q, out_tag_d;

    req_t head;
    req_t in_req;
    logic push, pop, ovf;

    // in_ready looks only at registered count and rst, never at out_ready.
    assign bus.in_ready = !rst && (count_q < 2'd2);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count_q != 2'd0) && (!out_valid_q || bus.out_ready);

    assign in_req = '{a: bus.in_a, b: bus.in_b, cin: bus.in_cin,
                      sub: bus.in_sub, tag: bus.in_tag};

    always_comb begin
        head   = fifo_q[rd_ptr_q];
        add_a  = '0;
        add_b  = '0;
        add_c0 = 1'b0;
        if (count_q != 2'd0) begin
            add_a  = head.a;
            add_b  = head.sub ? ~head.b : head.b;
            add_c0 = head.sub | head.cin;
        end
    end

    // Overflow uses the transformed B so add and subtract share one rule.
    assign ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                 (add_s[WIDTH-1] != add_a[WIDTH-1]);

    always_comb begin
        fifo_d      = fifo_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_tag_d   = out_tag_q;

        if (push) begin
            fifo_d[wr_ptr_q] = in_req;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d    = ~rd_ptr_q;
            out_valid_d = 1'b1;
            out_sum_d   = add_s[WIDTH-1:0];
            out_cout_d  = add_s[WIDTH];
            out_ovf_d   = ovf;
            out_tag_d   = head.tag;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            fifo_q      <= fifo_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_adder_issue_stage.sv
// Scoreboard bench for adder_issue_stage: the driver queues expected results,
// an independent monitor pops and compares on each output transfer.
module tb_adder_issue_stage;

    localparam int W = 32;
    localparam int T = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [T-1:0] tag;
    } exp_t;

    logic clk;
    logic rst;
    logic [W-1:0] add_a, add_b;
    logic         add_c0;
    logic [W:0]   add_s;

    adder_issue_stage_if #(.WIDTH(W), .TAGW(T)) bus ();

    adder_issue_stage #(.WIDTH(W), .GROUPSIZE(4), .TAGW(T)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .add_a (add_a),
        .add_b (add_b),
        .add_c0(add_c0),
        .add_s (add_s)
    );

    // Stand-in for the parallel-prefix adder.
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   out_cnt      = 0;
    int   stall_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares on transfer, checks data stability while stalled.
    initial begin
        exp_t e;
        logic stalled;
        logic [W-1:0] s_sum;
        logic s_cout, s_ovf;
        logic [T-1:0] s_tag;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !bus.out_valid) begin
                stalled = 1'b0;
            end else if (bus.out_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d sum 0x%0h, expected nothing",
                             bus.out_tag, bus.out_sum);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum",  64'(bus.out_sum),  64'(e.sum));
                    chk("out_cout", 64'(bus.out_cout), 64'(e.cout));
                    chk("out_ovf",  64'(bus.out_ovf),  64'(e.ovf));
                    chk("out_tag",  64'(bus.out_tag),  64'(e.tag));
                    out_cnt++;
                end
            end else begin
                if (stalled) begin
                    chk("stall_sum",  64'(bus.out_sum),  64'(s_sum));
                    chk("stall_cout", 64'(bus.out_cout), 64'(s_cout));
                    chk("stall_ovf",  64'(bus.out_ovf),  64'(s_ovf));
                    chk("stall_tag",  64'(bus.out_tag),  64'(s_tag));
                end
                s_sum = bus.out_sum; s_cout = bus.out_cout;
                s_ovf = bus.out_ovf; s_tag = bus.out_tag;
                stalled = 1'b1;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [T-1:0] tag, input logic [W-1:0] esum,
                        input logic ecout, input logic eovf);
        exp_t e;
        bit ok;
        ok = 1'b0;
        e.sum = esum; e.cout = ecout; e.ovf = eovf; e.tag = tag;
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                stall_cycles++;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tag %0d got in_ready=0 for 40 cycles, expected 1", tag);
        end
    endtask

    task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sub, input logic [T-1:0] tag);
        logic [W:0] r;
        logic o;
        if (sub) begin
            r = {1'b0, a} - {1'b0, b} + {1'b0, {W{1'b1}}} + 1'b1;
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        send(a, b, cin, sub, tag, r[W-1:0], r[W], o);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.in_tag = '0;
        bus.out_ready = 1'b1;

        #2;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum",   64'(bus.out_sum),   64'd0);
        chk("rst_out_cout",  64'(bus.out_cout),  64'd0);
        chk("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
        chk("rst_add_a",     64'(add_a),         64'd0);
        chk("rst_add_b",     64'(add_b),         64'd0);
        chk("rst_add_c0",    64'(add_c0),        64'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        // Single add and 2-cycle latency.
        send(32'h5, 32'h3, 1'b1, 1'b0, 4'd1, 32'h9, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("latency_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // Directed carry/borrow/overflow vectors, back to back.
        send(32'h5,        32'h7, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3, 32'h0,         1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd4, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'd5, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'hA,        32'h3, 1'b1, 1'b1, 4'd6, 32'h7,         1'b1, 1'b0);
        send(32'h0,        32'h0, 1'b1, 1'b0, 4'd7, 32'h1,         1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: three requests fill the stage, the fourth waits.
        bus.out_ready = 1'b0;
        send(32'h10, 32'h1, 1'b0, 1'b0, 4'd1, 32'h11, 1'b0, 1'b0);
        send(32'h20, 32'h2, 1'b0, 1'b0, 4'd2, 32'h22, 1'b0, 1'b0);
        send(32'h30, 32'h3, 1'b0, 1'b0, 4'd3, 32'h33, 1'b0, 1'b0);
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_a = 32'h40; bus.in_b = 32'h4; bus.in_tag = 4'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_out_tag",   64'(bus.out_tag),   64'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(32'h40, 32'h4, 1'b0, 1'b0, 4'd4, 32'h44, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Streaming: 100 random ops, no input stalls expected.
        stall_cycles = 0;
        base = out_cnt;
        for (int i = 0; i < 100; i++)
            send_model($urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 4'(i));
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_stalls",  64'(stall_cycles),   64'd0);
        chk("stream_outputs", 64'(out_cnt - base), 64'd100);
        chk("stream_pending", 64'(sb.size()),      64'd0);
        @(posedge clk);
        #1;

        // Reset mid-stream with a full FIFO and a held output.
        bus.out_ready = 1'b0;
        send_model(32'h1111, 32'h2222, 1'b0, 1'b0, 4'd9);
        send_model(32'h3333, 32'h1111, 1'b0, 1'b1, 4'd10);
        send_model(32'h5555, 32'h1, 1'b1, 1'b0, 4'd11);
        bus.in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_rst_in_ready",  64'(bus.in_ready),  64'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("midrst_out_sum",   64'(bus.out_sum),   64'd0);
        chk("midrst_out_tag",   64'(bus.out_tag),   64'd0);
        chk("midrst_add_a",     64'(add_a),         64'd0);
        chk("midrst_add_c0",    64'(add_c0),        64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'h100, 32'h23, 1'b0, 1'b0, 4'd12, 32'h123, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("post_rst_idle_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
